// File: rtl/uart_rx_ext.sv
`timescale 1ns/1ps
// UART receiver with 3-sample majority bit decisions, parity/stop checking and a
// one-entry valid/ready holding register that reports overruns.
module uart_rx_ext #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  sysclk,
    input  logic                  i_rst,
    input  logic                  i_rx,
    input  logic                  i_rx_serial,
    input  logic                  i_rx_ready,
    output logic                  o_rx_valid,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam int M  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_PRE = CW'(M - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(M);
    localparam logic [CW-1:0] CNT_DEC = CW'(M + 1);
    localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_error(input logic [DATA_WIDTH-1:0] d, input logic p);
        return ((^d) ^ p) != 1'(PARITY_ODD);
    endfunction

    state_t                state, state_n;
    logic                  rx_sync_p0, rx_sync_p1;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         bit_idx;
    logic                  samp_pre, samp_mid;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_bit;
    logic                  frame_bad;
    logic                  bit_v;
    logic                  decide, bit_end;
    logic                  commit, load_ok;
    logic                  par_err_n;

    // Stage p0/p1: two-flop synchroniser, parked at idle level while disabled
    always_ff @(posedge sysclk) begin
        if (i_rst || !i_rx) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= i_rx_serial;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    assign bit_v     = majority3(samp_pre, samp_mid, rx_sync_p1);
    assign decide    = (cnt == CNT_DEC);
    assign bit_end   = (cnt == CNT_END);
    assign load_ok   = !o_rx_valid || i_rx_ready;
    assign par_err_n = (PARITY_EN != 0) ? parity_error(shift_reg, par_bit) : 1'b0;

    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        commit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_sync_p1) state_n = S_START;
            end
            S_START: begin
                if (decide && bit_v) state_n = S_IDLE;
                else if (bit_end)    state_n = S_DATA;
            end
            S_DATA: begin
                if (bit_end && bit_idx == IDX_LAST)
                    state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_end) state_n = S_STOP;
            end
            S_STOP: begin
                // Commit mid-way through the last stop bit so the next start edge is not missed
                if (decide && bit_idx == STOP_LAST) begin
                    commit  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (!i_rx) begin
            state_n = S_IDLE;
            commit  = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            frame_bad <= 1'b0;
        end else begin
            if (state == S_IDLE || state_n == S_IDLE || bit_end)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (state != state_n)
                bit_idx <= '0;
            else if (bit_end && (state == S_DATA || state == S_STOP))
                bit_idx <= bit_idx + IW'(1);

            if (state == S_IDLE)
                frame_bad <= 1'b0;
            else if (state == S_STOP && decide && !bit_v)
                frame_bad <= 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (cnt == CNT_PRE) samp_pre <= rx_sync_p1;
        if (cnt == CNT_MID) samp_mid <= rx_sync_p1;
        if (state == S_DATA && decide)
            shift_reg <= {bit_v, shift_reg[DATA_WIDTH-1:1]};
        if (state == S_PARITY && decide)
            par_bit <= bit_v;
    end

    // Holding register: a commit may refill it in the same cycle it is drained
    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            o_rx_valid   <= 1'b0;
            o_rx_data    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= commit && !load_ok;
            if (commit && load_ok) begin
                o_rx_valid   <= 1'b1;
                o_rx_data    <= shift_reg;
                o_parity_err <= par_err_n;
                o_frame_err  <= frame_bad | !bit_v;
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
`timescale 1ns/1ps
// Directed and randomised bench for uart_rx_ext: three configurations (8N1, 8E1, 8N2)
// checked against a frame-level model of the expected data and status flags.
module tb_uart_rx_ext;

    localparam int CPB = 16;

    logic sysclk = 1'b0;
    logic rst;
    logic rx_a, ser_a, rdy_a, vld_a, pe_a, fe_a, ov_a;
    logic rx_b, ser_b, rdy_b, vld_b, pe_b, fe_b, ov_b;
    logic rx_c, ser_c, rdy_c, vld_c, pe_c, fe_c, ov_c;
    logic [7:0] dat_a, dat_b, dat_c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_edge = 0;
    int t_rise_a = 0;
    logic va_prev = 1'b0;
    int ov_cnt_a = 0, ov_cnt_b = 0, ov_cnt_c = 0;
    int vcyc_a = 0;
    logic [7:0] got_a[$];

    always #5 sysclk = ~sysclk;

    uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
        .sysclk(sysclk), .i_rst(rst), .i_rx(rx_a), .i_rx_serial(ser_a), .i_rx_ready(rdy_a),
        .o_rx_valid(vld_a), .o_rx_data(dat_a), .o_parity_err(pe_a), .o_frame_err(fe_a), .o_overrun(ov_a));

    uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
        .sysclk(sysclk), .i_rst(rst), .i_rx(rx_b), .i_rx_serial(ser_b), .i_rx_ready(rdy_b),
        .o_rx_valid(vld_b), .o_rx_data(dat_b), .o_parity_err(pe_b), .o_frame_err(fe_b), .o_overrun(ov_b));

    uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_c (
        .sysclk(sysclk), .i_rst(rst), .i_rx(rx_c), .i_rx_serial(ser_c), .i_rx_ready(rdy_c),
        .o_rx_valid(vld_c), .o_rx_data(dat_c), .o_parity_err(pe_c), .o_frame_err(fe_c), .o_overrun(ov_c));

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        va_prev <= vld_a;
        if (vld_a && !va_prev) t_rise_a <= cyc;
        if (vld_a) vcyc_a <= vcyc_a + 1;
        if (vld_a && rdy_a) got_a.push_back(dat_a);
        if (ov_a) ov_cnt_a <= ov_cnt_a + 1;
        if (ov_b) ov_cnt_b <= ov_cnt_b + 1;
        if (ov_c) ov_cnt_c <= ov_cnt_c + 1;
    end

    // Wire image of a frame, LSB first: start, 8 data bits, optional parity, stop bit(s)
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input bit has_par,
                                               input logic pb, input logic s1, input logic s2);
        logic [15:0] f;
        int n;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        n = 9;
        if (has_par) begin
            f[n] = pb;
            n++;
        end
        f[n] = s1;
        f[n + 1] = s2;
        return f;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int inst, input logic v);
        case (inst)
            0: ser_a = v;
            1: ser_b = v;
            default: ser_c = v;
        endcase
    endtask

    task automatic send(input int inst, input logic [15:0] bits, input int nbits, input int gap);
        @(posedge sysclk);
        #1;
        t_edge = cyc;
        for (int i = 0; i < nbits; i++) begin
            drive(inst, bits[i]);
            repeat (CPB) @(posedge sysclk);
            #1;
        end
        drive(inst, 1'b1);
        repeat (gap) @(posedge sysclk);
        #1;
    endtask

    task automatic pulse_ready(input int inst, input string tag);
        case (inst)
            0: rdy_a = 1'b1;
            1: rdy_b = 1'b1;
            default: rdy_c = 1'b1;
        endcase
        @(posedge sysclk);
        #1;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        rdy_c = 1'b0;
        case (inst)
            0: check(tag, vld_a, 1'b0);
            1: check(tag, vld_b, 1'b0);
            default: check(tag, vld_c, 1'b0);
        endcase
    endtask

    initial begin
        logic [7:0] d;
        logic pb, s1, s2;
        int lat, v0, o0;
        logic [7:0] tp[4];

        rst = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        ser_a = 1'b1; ser_b = 1'b1; ser_c = 1'b1;
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_valid", vld_a, 1'b0);
        check("rst_data", dat_a, 8'h00);
        check("rst_perr", pe_a, 1'b0);
        check("rst_ferr", fe_a, 1'b0);
        check("rst_ovr", ov_a, 1'b0);
        rst = 1'b0;
        repeat (5) @(posedge sysclk);

        // Basic 8N1 receive and latency from pin edge
        send(0, frame_bits(8'hA5, 0, 1'b0, 1'b1, 1'b1), 10, 20);
        lat = t_rise_a - t_edge;
        check("basic_latency_ok", (lat >= 156 && lat <= 158), 1'b1);
        check("basic_valid", vld_a, 1'b1);
        check("basic_data", dat_a, 8'hA5);
        check("basic_perr", pe_a, 1'b0);
        check("basic_ferr", fe_a, 1'b0);
        pulse_ready(0, "basic_drain");

        // Even parity
        send(1, frame_bits(8'h03, 1, 1'b0, 1'b1, 1'b1), 11, 20);
        check("par_ok_valid", vld_b, 1'b1);
        check("par_ok_data", dat_b, 8'h03);
        check("par_ok_perr", pe_b, 1'b0);
        pulse_ready(1, "par_ok_drain");
        send(1, frame_bits(8'h03, 1, 1'b1, 1'b1, 1'b1), 11, 20);
        check("par_bad_data", dat_b, 8'h03);
        check("par_bad_perr", pe_b, 1'b1);
        check("par_bad_ferr", fe_b, 1'b0);
        pulse_ready(1, "par_bad_drain");

        for (int k = 0; k < 6; k++) begin
            d  = 8'($urandom);
            pb = 1'($urandom_range(0, 1));
            s1 = ($urandom_range(0, 3) != 0);
            send(1, frame_bits(d, 1, pb, s1, 1'b1), 11, 24);
            check("rnd_b_valid", vld_b, 1'b1);
            check("rnd_b_data", dat_b, d);
            check("rnd_b_perr", pe_b, (^d) ^ pb);
            check("rnd_b_ferr", fe_b, !s1);
            pulse_ready(1, "rnd_b_drain");
        end

        // Two stop bits, second one low
        send(2, frame_bits(8'h5A, 0, 1'b0, 1'b1, 1'b0), 11, 24);
        check("stop2_valid", vld_c, 1'b1);
        check("stop2_data", dat_c, 8'h5A);
        check("stop2_ferr", fe_c, 1'b1);
        check("stop2_perr", pe_c, 1'b0);
        pulse_ready(2, "stop2_drain");
        send(2, frame_bits(8'h96, 0, 1'b0, 1'b1, 1'b1), 11, 24);
        check("stop2_next_data", dat_c, 8'h96);
        check("stop2_next_ferr", fe_c, 1'b0);
        pulse_ready(2, "stop2_next_drain");
        for (int k = 0; k < 4; k++) begin
            d  = 8'($urandom);
            s1 = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            send(2, frame_bits(d, 0, 1'b0, s1, s2), 11, 24);
            check("rnd_c_data", dat_c, d);
            check("rnd_c_ferr", fe_c, !(s1 && s2));
            pulse_ready(2, "rnd_c_drain");
        end

        // Short low glitch on idle line
        @(posedge sysclk);
        #1;
        ser_a = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        ser_a = 1'b1;
        repeat (40) @(posedge sysclk);
        #1;
        check("glitch_no_valid", vld_a, 1'b0);
        send(0, frame_bits(8'h3C, 0, 1'b0, 1'b1, 1'b1), 10, 20);
        check("post_glitch_valid", vld_a, 1'b1);
        check("post_glitch_data", dat_a, 8'h3C);
        pulse_ready(0, "post_glitch_drain");

        // Overrun: second frame dropped while the first is held
        o0 = ov_cnt_a;
        send(0, frame_bits(8'h11, 0, 1'b0, 1'b1, 1'b1), 10, 0);
        send(0, frame_bits(8'h22, 0, 1'b0, 1'b1, 1'b1), 10, 20);
        check("ovr_valid", vld_a, 1'b1);
        check("ovr_held_data", dat_a, 8'h11);
        check("ovr_pulse_cycles", ov_cnt_a - o0, 1);
        pulse_ready(0, "ovr_drain");

        // Back-to-back frames with ready tied high
        got_a.delete();
        v0 = vcyc_a;
        o0 = ov_cnt_a;
        tp[0] = 8'h00; tp[1] = 8'hFF; tp[2] = 8'h81; tp[3] = 8'h7E;
        rdy_a = 1'b1;
        for (int k = 0; k < 4; k++)
            send(0, frame_bits(tp[k], 0, 1'b0, 1'b1, 1'b1), 10, (k == 3) ? 20 : 0);
        rdy_a = 1'b0;
        check("tput_count", got_a.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < got_a.size()) check("tput_data", got_a[k], tp[k]);
        check("tput_valid_cycles", vcyc_a - v0, 4);
        check("tput_no_ovr", ov_cnt_a - o0, 0);

        // Receive disable mid-frame abandons it
        o0 = ov_cnt_a;
        @(posedge sysclk);
        #1;
        ser_a = 1'b0;
        repeat (CPB * 4) @(posedge sysclk);
        #1;
        rx_a = 1'b0;
        ser_a = 1'b1;
        repeat (200) @(posedge sysclk);
        #1;
        rx_a = 1'b1;
        repeat (20) @(posedge sysclk);
        #1;
        check("disable_no_valid", vld_a, 1'b0);
        check("disable_no_ovr", ov_cnt_a - o0, 0);
        send(0, frame_bits(8'hC3, 0, 1'b0, 1'b1, 1'b1), 10, 20);
        check("reenable_valid", vld_a, 1'b1);
        check("reenable_data", dat_a, 8'hC3);
        rx_a = 1'b0;
        repeat (5) @(posedge sysclk);
        #1;
        check("disable_hold_valid", vld_a, 1'b1);
        check("disable_hold_data", dat_a, 8'hC3);
        pulse_ready(0, "disable_drain");
        rx_a = 1'b1;
        repeat (5) @(posedge sysclk);

        // Reset while a frame is held
        send(0, frame_bits(8'h5E, 0, 1'b0, 1'b0, 1'b1), 10, 20);
        check("prerst_valid", vld_a, 1'b1);
        check("prerst_ferr", fe_a, 1'b1);
        rst = 1'b1;
        @(posedge sysclk);
        #1;
        check("rst2_valid", vld_a, 1'b0);
        check("rst2_data", dat_a, 8'h00);
        check("rst2_perr", pe_a, 1'b0);
        check("rst2_ferr", fe_a, 1'b0);
        check("rst2_ovr", ov_a, 1'b0);
        rst = 1'b0;
        repeat (5) @(posedge sysclk);
        #1;
        check("b_no_ovr", ov_cnt_b, 0);
        check("c_no_ovr", ov_cnt_c, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ext.md
# uart_rx_ext

Parametrised UART receiver: the next generation of the project's serial receive path on the Zybo Z7-20. Data width, parity, stop-bit count and bit period are configurable. Each bit is decided by a 3-sample majority vote, which rejects glitches. Every received frame is committed with parity and framing status into a one-entry holding register. The register is drained through a valid/ready handshake and an overrun is reported when the consumer is too slow. The block sits between the synchronised RX pin and the byte consumer (loopback/TX path or LED/debug logic), gated by the same receive-mode enable as today.

## Interface
- CLKS_PER_BIT, 1085 — sysclk cycles per bit (125 MHz / 115200); legal range ≥ 8.
- DATA_WIDTH, 8 — data bits per frame; legal range 5..9.
- PARITY_EN, 0 — 1 inserts one parity bit after the data bits.
- PARITY_ODD, 0 — 0 even parity, 1 odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1 — 1 or 2.

- sysclk  input  1  system clock; single clock domain.
- i_rst  input  1  reset; synchronous, active-high.
- i_rx  input  1  receive-mode enable; high = active.
- i_rx_serial  input  1  asynchronous serial line; idles high.
- i_rx_ready  input  1  consumer accepts the held frame.
- o_rx_valid  output  1  holding register contains an unconsumed frame.
- o_rx_data  output  DATA_WIDTH  received data, LSB first on the wire.
- o_parity_err  output  1  status of the held frame; 0 when PARITY_EN=0.
- o_frame_err  output  1  status of the held frame; 1 if any stop bit was decided as 0.
- o_overrun  output  1  one-cycle pulse when a completed frame is dropped.

## Operation
- The input passes through a 2-flop synchroniser; both flops reset to 1.
- Counter width: $clog2(CLKS_PER_BIT). The counter runs 0..CLKS_PER_BIT-1 per bit. M = CLKS_PER_BIT/2 (integer division).
- Sampling: the synchronised line is sampled at counter values M-1, M and M+1. The bit value is the 2-of-3 majority, decided at count M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: counter cleared, bit index cleared. If the synchronised line is 0, go to START with counter=0 on the first START cycle.
- START: decide at M+1. If the majority is 1 (glitch), return to IDLE. Otherwise continue; at count CLKS_PER_BIT-1, go to DATA.
- DATA: shift the decided bits into bit positions 0..DATA_WIDTH-1. After the last data bit period, go to PARITY if PARITY_EN, else go to STOP.
- PARITY: the error condition is XOR(data bits, parity bit) != PARITY_ODD.
- STOP: for each stop bit, a decided 0 sets the frame-error flag.
  - On the final stop bit, commit at count M+1 and go to IDLE immediately, without waiting for the end of the bit. This allows resync on the next start edge.
- Commit (one cycle), evaluated in priority order:
  - If o_rx_valid=0, or (o_rx_valid=1 and i_rx_ready=1) in the same cycle: load data and both error flags; o_rx_valid=1 next cycle.
  - Otherwise: the frame is discarded, the held frame is unchanged, and o_overrun pulses high next cycle for exactly one cycle.
- Handshake: the frame is consumed in any cycle with o_rx_valid & i_rx_ready, and o_rx_valid drops on the next cycle unless a commit loads a new frame in that same cycle.
  - o_rx_data and the error flags are stable while o_rx_valid=1.
  - i_rx_ready while o_rx_valid=0 has no effect.
- Frames with errors are committed and handshaken like good frames; the consumer decides what to do with them.
- i_rx=0:
  - The FSM is forced to IDLE and any in-progress frame is discarded without a commit or overrun.
  - The synchroniser is forced to 1.
  - The holding register and o_rx_valid are preserved and drainable.

## Timing
- Reset values: o_rx_valid=0, o_rx_data=0, o_parity_err=0, o_frame_err=0, o_overrun=0. FSM=IDLE, counters 0, synchroniser=1.
- i_rst has priority over i_rx and all other inputs. Reset mid-frame abandons the frame and clears the holding register.
- Latency: let L = DATA_WIDTH + PARITY_EN + STOP_BITS.
  - Commit occurs L·CLKS_PER_BIT + M + 1 cycles after the first START cycle.
  - The first START cycle is 3 cycles after the pin falling edge: 2 synchroniser cycles plus the IDLE detect cycle.
  - o_rx_valid rises 1 cycle after commit.
- Back-to-back frames (stop bit directly followed by start) are received without loss. A new start is detectable from the cycle after commit.
- The minimum accepted start pulse is about M+2 cycles. Pulses of 1 sample or shorter than 2 of the 3 samples are rejected.

## Test plan
- Basic receive: CLKS_PER_BIT=16, 8N1, send 0xA5, i_rx_ready=0 → o_rx_valid rises 157±1 cycles after the pin edge with o_rx_data=0xA5 and no errors. Pulse ready → valid drops on the next cycle.
- Parity: PARITY_EN=1, PARITY_ODD=0.
  - Send 0x03 with parity bit 0 → o_parity_err=0.
  - Send 0x03 with parity bit 1 → o_parity_err=1, data 0x03.
- Framing and stop bits: STOP_BITS=2, send 0x5A with the second stop bit low → o_frame_err=1, data 0x5A, then return to IDLE.
- Glitch and overrun:
  - A 3-cycle low glitch on an idle line → no valid and the FSM returns to IDLE.
  - Two frames 0x11 then 0x22 with ready held low → 0x11 remains held and o_overrun pulses for exactly 1 cycle.
- Throughput: ready tied high, 4 back-to-back frames 0x00, 0xFF, 0x81, 0x7E → 4 single-cycle valids in order, no overrun.
- Enable and reset:
  - Deassert i_rx mid-frame → no commit.
  - Re-enable and send 0xC3 → 0xC3 is received.
  - Assert i_rst while o_rx_valid=1 → all outputs are 0 on the next cycle.
